// File: rtl/ysyx_axi_req_sched.sv
// rtl/ysyx_axi_req_sched.sv - single-port AXI4 request scheduler sharing io_master between IFU fetch and LSU load/store
module ysyx_axi_req_sched #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ifu_arvalid,
    input  logic [ADDR_W-1:0] ifu_araddr,
    output logic [DATA_W-1:0] ifu_rdata_o,
    output logic              ifu_rvalid_o,
    input  logic              lsu_arvalid,
    input  logic [ADDR_W-1:0] lsu_araddr,
    input  logic [2:0]        lsu_arsize,
    output logic [DATA_W-1:0] lsu_rdata_o,
    output logic              lsu_rvalid_o,
    input  logic              lsu_awvalid,
    input  logic [ADDR_W-1:0] lsu_awaddr,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [3:0]        lsu_wstrb,
    output logic              lsu_wready_o,
    output logic              err_o,
    output logic              io_master_arvalid,
    output logic [ADDR_W-1:0] io_master_araddr,
    output logic [2:0]        io_master_arsize,
    output logic [3:0]        io_master_arid,
    output logic [7:0]        io_master_arlen,
    output logic [1:0]        io_master_arburst,
    input  logic              io_master_arready,
    input  logic              io_master_rvalid,
    input  logic [63:0]       io_master_rdata,
    input  logic [1:0]        io_master_rresp,
    input  logic              io_master_rlast,
    input  logic [3:0]        io_master_rid,
    output logic              io_master_rready,
    output logic              io_master_awvalid,
    output logic [ADDR_W-1:0] io_master_awaddr,
    output logic [2:0]        io_master_awsize,
    output logic [3:0]        io_master_awid,
    output logic [7:0]        io_master_awlen,
    output logic [1:0]        io_master_awburst,
    input  logic              io_master_awready,
    output logic              io_master_wvalid,
    output logic [63:0]       io_master_wdata,
    output logic [7:0]        io_master_wstrb,
    output logic              io_master_wlast,
    input  logic              io_master_wready,
    input  logic              io_master_bvalid,
    input  logic [1:0]        io_master_bresp,
    input  logic [3:0]        io_master_bid,
    output logic              io_master_bready
);
    typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR_AW, WR_B} state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t              state, state_n;
    logic                owner_ifu;
    logic [ADDR_W-1:0]   addr_q;
    logic [2:0]          size_q;
    logic [7:0]          wstrb_q;
    logic [DATA_W-1:0]   wword_q;
    logic                aw_done, w_done;
    logic [3:0]          starve_cnt;
    logic                grant_ifu, grant_rd, grant_wr;
    logic [2:0]          wsize;
    logic [3:0]          strb_sh;
    logic [DATA_W-1:0]   wword_n, rd_lane, rd_shift;
    logic                unused_sink;

    assign unused_sink = ^{io_master_rlast, io_master_rid, io_master_bid};

    // The IFU override only applies once the LSU has won STARVE_MAX times in a row.
    always_comb begin
        grant_ifu = 1'b0;
        grant_rd  = 1'b0;
        grant_wr  = 1'b0;
        if (state == IDLE) begin
            if (starve_cnt == STARVE_LIM && ifu_arvalid) grant_ifu = 1'b1;
            else if (lsu_awvalid)                         grant_wr  = 1'b1;
            else if (lsu_arvalid)                         grant_rd  = 1'b1;
            else if (ifu_arvalid)                         grant_ifu = 1'b1;
        end
    end

    always_comb begin
        case ($countones(lsu_wstrb))
            1:       wsize = 3'd0;
            2:       wsize = 3'd1;
            default: wsize = 3'd2;
        endcase
    end

    assign strb_sh  = lsu_wstrb << lsu_awaddr[1:0];
    assign wword_n  = lsu_wdata << {lsu_awaddr[1:0], 3'b000};
    assign rd_lane  = addr_q[2] ? io_master_rdata[63:32] : io_master_rdata[31:0];
    assign rd_shift = rd_lane >> {addr_q[1:0], 3'b000};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (grant_wr) state_n = WR_AW;
                     else if (grant_rd || grant_ifu) state_n = RD_A;
            RD_A:    if (io_master_arready) state_n = RD_D;
            RD_D:    if (io_master_rvalid) state_n = IDLE;
            WR_AW:   if ((aw_done || io_master_awready) && (w_done || io_master_wready)) state_n = WR_B;
            WR_B:    if (io_master_bvalid) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign io_master_arvalid = (state == RD_A);
    assign io_master_araddr  = addr_q;
    assign io_master_arsize  = size_q;
    assign io_master_arid    = 4'd0;
    assign io_master_arlen   = 8'd0;
    assign io_master_arburst = 2'b01;
    assign io_master_rready  = (state == RD_D);
    assign io_master_awvalid = (state == WR_AW) && !aw_done;
    assign io_master_awaddr  = addr_q;
    assign io_master_awsize  = size_q;
    assign io_master_awid    = 4'd0;
    assign io_master_awlen   = 8'd0;
    assign io_master_awburst = 2'b01;
    assign io_master_wvalid  = (state == WR_AW) && !w_done;
    assign io_master_wdata   = {wword_q, wword_q};
    assign io_master_wstrb   = wstrb_q;
    assign io_master_wlast   = io_master_wvalid;
    assign io_master_bready  = (state == WR_B);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_ifu    <= 1'b0;
            addr_q       <= '0;
            size_q       <= 3'd0;
            wstrb_q      <= 8'd0;
            wword_q      <= '0;
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
            starve_cnt   <= 4'd0;
            ifu_rdata_o  <= '0;
            lsu_rdata_o  <= '0;
            ifu_rvalid_o <= 1'b0;
            lsu_rvalid_o <= 1'b0;
            lsu_wready_o <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            ifu_rvalid_o <= 1'b0;
            lsu_rvalid_o <= 1'b0;
            lsu_wready_o <= 1'b0;
            err_o        <= 1'b0;
            if (grant_ifu || grant_rd || grant_wr) begin
                owner_ifu <= grant_ifu;
                aw_done   <= 1'b0;
                w_done    <= 1'b0;
            end
            if (grant_ifu) begin
                addr_q <= ifu_araddr;
                size_q <= 3'd2;
            end
            if (grant_rd) begin
                addr_q <= lsu_araddr;
                size_q <= lsu_arsize;
            end
            if (grant_wr) begin
                addr_q  <= lsu_awaddr;
                size_q  <= wsize;
                wstrb_q <= lsu_awaddr[2] ? {strb_sh, 4'b0000} : {4'b0000, strb_sh};
                wword_q <= wword_n;
            end
            if (grant_ifu)
                starve_cnt <= 4'd0;
            else if ((grant_rd || grant_wr) && ifu_arvalid && starve_cnt != STARVE_LIM)
                starve_cnt <= starve_cnt + 4'd1;
            if (io_master_awvalid && io_master_awready) aw_done <= 1'b1;
            if (io_master_wvalid && io_master_wready)   w_done  <= 1'b1;
            if (state == RD_D && io_master_rvalid) begin
                if (owner_ifu) begin
                    ifu_rdata_o  <= rd_shift;
                    ifu_rvalid_o <= 1'b1;
                end else begin
                    lsu_rdata_o  <= rd_shift;
                    lsu_rvalid_o <= 1'b1;
                end
                err_o <= |io_master_rresp;
            end
            if (state == WR_B && io_master_bvalid) begin
                lsu_wready_o <= 1'b1;
                err_o        <= |io_master_bresp;
            end
        end
    end
endmodule

// File: tb/tb_ysyx_axi_req_sched.sv
// tb/tb_ysyx_axi_req_sched.sv - scoreboard bench for ysyx_axi_req_sched with a behavioural AXI slave
module tb_ysyx_axi_req_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        ifu_arvalid, lsu_arvalid, lsu_awvalid;
    logic [31:0] ifu_araddr, lsu_araddr, lsu_awaddr, lsu_wdata;
    logic [2:0]  lsu_arsize;
    logic [3:0]  lsu_wstrb;
    logic [31:0] ifu_rdata_o, lsu_rdata_o;
    logic        ifu_rvalid_o, lsu_rvalid_o, lsu_wready_o, err_o;
    logic        io_master_arvalid, io_master_arready, io_master_rvalid, io_master_rlast, io_master_rready;
    logic [31:0] io_master_araddr, io_master_awaddr;
    logic [2:0]  io_master_arsize, io_master_awsize;
    logic [3:0]  io_master_arid, io_master_rid, io_master_awid, io_master_bid;
    logic [7:0]  io_master_arlen, io_master_awlen, io_master_wstrb;
    logic [1:0]  io_master_arburst, io_master_awburst, io_master_rresp, io_master_bresp;
    logic [63:0] io_master_rdata, io_master_wdata;
    logic        io_master_awvalid, io_master_awready, io_master_wvalid, io_master_wlast, io_master_wready;
    logic        io_master_bvalid, io_master_bready;

    ysyx_axi_req_sched dut (
        .clk(clk), .rst(rst),
        .ifu_arvalid(ifu_arvalid), .ifu_araddr(ifu_araddr), .ifu_rdata_o(ifu_rdata_o), .ifu_rvalid_o(ifu_rvalid_o),
        .lsu_arvalid(lsu_arvalid), .lsu_araddr(lsu_araddr), .lsu_arsize(lsu_arsize),
        .lsu_rdata_o(lsu_rdata_o), .lsu_rvalid_o(lsu_rvalid_o),
        .lsu_awvalid(lsu_awvalid), .lsu_awaddr(lsu_awaddr), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
        .lsu_wready_o(lsu_wready_o), .err_o(err_o),
        .io_master_arvalid(io_master_arvalid), .io_master_araddr(io_master_araddr), .io_master_arsize(io_master_arsize),
        .io_master_arid(io_master_arid), .io_master_arlen(io_master_arlen), .io_master_arburst(io_master_arburst),
        .io_master_arready(io_master_arready),
        .io_master_rvalid(io_master_rvalid), .io_master_rdata(io_master_rdata), .io_master_rresp(io_master_rresp),
        .io_master_rlast(io_master_rlast), .io_master_rid(io_master_rid), .io_master_rready(io_master_rready),
        .io_master_awvalid(io_master_awvalid), .io_master_awaddr(io_master_awaddr), .io_master_awsize(io_master_awsize),
        .io_master_awid(io_master_awid), .io_master_awlen(io_master_awlen), .io_master_awburst(io_master_awburst),
        .io_master_awready(io_master_awready),
        .io_master_wvalid(io_master_wvalid), .io_master_wdata(io_master_wdata), .io_master_wstrb(io_master_wstrb),
        .io_master_wlast(io_master_wlast), .io_master_wready(io_master_wready),
        .io_master_bvalid(io_master_bvalid), .io_master_bresp(io_master_bresp), .io_master_bid(io_master_bid),
        .io_master_bready(io_master_bready)
    );

    typedef struct {
        int          kind;
        logic [31:0] data;
        logic        err;
        int          lat;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] ld_q[$];
    int          n_cmp = 0, n_bad = 0, cyc = 0, start_cyc = 0;
    int          ar_delay = 0, aw_delay = 0, w_delay = 0;
    logic [63:0] sl_rdata = 64'h11223344_55667788;
    logic [1:0]  sl_rresp = 2'b00, sl_bresp = 2'b00;
    bit          chk_ar = 0, chk_w = 0;
    logic [31:0] exp_araddr, exp_awaddr;
    logic [2:0]  exp_arsize, exp_awsize;
    logic [63:0] exp_wdata;
    logic [7:0]  exp_wstrb;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input logic [31:0] data, input logic err, input int lat);
        exp_t e;
        e.kind = kind; e.data = data; e.err = err; e.lat = lat;
        sb_q.push_back(e);
    endtask

    task automatic handle(input int kind, input logic [31:0] data);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_pulse: got pulse kind %0d expected none", kind);
        end else begin
            e = sb_q.pop_front();
            check("pulse_kind", 64'(kind), 64'(e.kind));
            if (kind != 2) check("pulse_data", 64'(data), 64'(e.data));
            check("pulse_err", 64'(err_o), 64'(e.err));
            if (e.lat >= 0) check("latency", 64'(cyc - start_cyc), 64'(e.lat));
        end
        if (kind == 0) ifu_arvalid = 1'b0;
        if (kind == 1) begin
            if (ld_q.size() > 0) lsu_araddr = ld_q.pop_front();
            else lsu_arvalid = 1'b0;
        end
        if (kind == 2) lsu_awvalid = 1'b0;
    endtask

    // Slave model: decisions at negedge, handshakes inferred from what was visible the previous negedge.
    logic p_arv, p_rr, p_awv, p_wv, p_br;
    bit   aw_got, w_got;
    int   ar_w, aw_w, w_w;
    always @(negedge clk) begin
        if (rst) begin
            io_master_arready = 0; io_master_rvalid = 0; io_master_rdata = '0; io_master_rresp = 0;
            io_master_awready = 0; io_master_wready = 0; io_master_bvalid = 0; io_master_bresp = 0;
            aw_got = 0; w_got = 0; ar_w = 0; aw_w = 0; w_w = 0;
        end else begin
            if (io_master_rvalid && p_rr) io_master_rvalid = 0;
            if (io_master_bvalid && p_br) io_master_bvalid = 0;
            if (io_master_arready && p_arv) begin
                io_master_rvalid = 1; io_master_rdata = sl_rdata; io_master_rresp = sl_rresp;
            end
            if (io_master_awready && p_awv) aw_got = 1;
            if (io_master_wready && p_wv)   w_got  = 1;
            if (aw_got && w_got) begin
                io_master_bvalid = 1; io_master_bresp = sl_bresp; aw_got = 0; w_got = 0;
            end
            if (io_master_arvalid) begin io_master_arready = (ar_w >= ar_delay); ar_w++; end
            else begin io_master_arready = 0; ar_w = 0; end
            if (io_master_awvalid) begin io_master_awready = (aw_w >= aw_delay); aw_w++; end
            else begin io_master_awready = 0; aw_w = 0; end
            if (io_master_wvalid) begin io_master_wready = (w_w >= w_delay); w_w++; end
            else begin io_master_wready = 0; w_w = 0; end
        end
        p_arv = io_master_arvalid; p_rr = io_master_rready; p_awv = io_master_awvalid;
        p_wv = io_master_wvalid; p_br = io_master_bready;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (ifu_rvalid_o) handle(0, ifu_rdata_o);
            if (lsu_rvalid_o) handle(1, lsu_rdata_o);
            if (lsu_wready_o) handle(2, 32'd0);
            if (err_o && !(ifu_rvalid_o || lsu_rvalid_o || lsu_wready_o)) begin
                n_cmp++; n_bad++;
                $display("FAIL lone_err: got err_o=1 expected err only with a completion pulse");
            end
            if (chk_ar && io_master_arvalid) begin
                check("araddr", 64'(io_master_araddr), 64'(exp_araddr));
                check("arsize", 64'(io_master_arsize), 64'(exp_arsize));
                check("ar_const", 64'({io_master_arlen, io_master_arburst, io_master_arid}), 64'({8'd0, 2'b01, 4'd0}));
            end
            if (chk_w && io_master_awvalid) begin
                check("awaddr", 64'(io_master_awaddr), 64'(exp_awaddr));
                check("awsize", 64'(io_master_awsize), 64'(exp_awsize));
                check("aw_const", 64'({io_master_awlen, io_master_awburst, io_master_awid}), 64'({8'd0, 2'b01, 4'd0}));
            end
            if (chk_w && io_master_wvalid) begin
                check("wdata", io_master_wdata, exp_wdata);
                check("wstrb", 64'(io_master_wstrb), 64'(exp_wstrb));
                check("wlast", 64'(io_master_wlast), 64'd1);
            end
        end
    end

    task automatic wait_drain();
        int k = 0;
        while (sb_q.size() != 0 && k < 200) begin @(negedge clk); k++; end
        if (sb_q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL timeout: got %0d responses outstanding expected 0", sb_q.size());
            sb_q.delete(); ld_q.delete();
            ifu_arvalid = 0; lsu_arvalid = 0; lsu_awvalid = 0;
        end
        repeat (2) @(negedge clk);
        chk_ar = 0; chk_w = 0;
    endtask

    task automatic load(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d, input logic e, input int lat);
        exp_araddr = a; exp_arsize = sz; chk_ar = 1;
        push(1, d, e, lat);
        start_cyc = cyc; lsu_araddr = a; lsu_arsize = sz; lsu_arvalid = 1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         input logic [2:0] esz, input logic [63:0] ed, input logic [7:0] es,
                         input logic e, input int lat);
        exp_awaddr = a; exp_awsize = esz; exp_wdata = ed; exp_wstrb = es; chk_w = 1;
        push(2, 32'd0, e, lat);
        start_cyc = cyc; lsu_awaddr = a; lsu_wdata = d; lsu_wstrb = s; lsu_awvalid = 1;
    endtask

    initial begin
        ifu_arvalid = 0; lsu_arvalid = 0; lsu_awvalid = 0;
        ifu_araddr = 0; lsu_araddr = 0; lsu_awaddr = 0; lsu_wdata = 0; lsu_arsize = 0; lsu_wstrb = 0;
        io_master_rlast = 1; io_master_rid = 0; io_master_bid = 0;
        repeat (3) @(negedge clk);
        check("rst_valids", 64'({io_master_arvalid, io_master_awvalid, io_master_wvalid, io_master_rready, io_master_bready}), 64'd0);
        check("rst_pulses", 64'({ifu_rvalid_o, lsu_rvalid_o, lsu_wready_o, err_o}), 64'd0);
        check("rst_data", 64'({ifu_rdata_o, lsu_rdata_o}), 64'd0);
        rst = 0;
        repeat (2) @(negedge clk);

        load(32'h8000_0006, 3'd1, 32'h0000_1122, 1'b0, 3);
        wait_drain();

        aw_delay = 3;
        store(32'h8000_0005, 32'h0000_00AB, 4'h1, 3'd0, 64'h0000AB00_0000AB00, 8'h20, 1'b0, 6);
        wait_drain();
        aw_delay = 0;

        ar_delay = 5; sl_rresp = 2'b10;
        load(32'h8000_0001, 3'd0, 32'h0055_6677, 1'b1, 8);
        wait_drain();
        ar_delay = 0; sl_rresp = 2'b00;

        sl_bresp = 2'b10;
        store(32'h8000_0002, 32'h0000_1234, 4'h3, 3'd1, 64'h12340000_12340000, 8'h0C, 1'b1, 3);
        wait_drain();
        sl_bresp = 2'b00;

        exp_araddr = 32'h8000_0004; exp_arsize = 3'd2; chk_ar = 1;
        push(0, 32'h1122_3344, 1'b0, 3);
        start_cyc = cyc; ifu_araddr = 32'h8000_0004; ifu_arvalid = 1;
        wait_drain();

        push(2, 32'd0, 1'b0, -1);
        push(1, 32'h1122_3344, 1'b0, -1);
        push(0, 32'h5566_7788, 1'b0, -1);
        lsu_awaddr = 32'h8000_0000; lsu_wdata = 32'hDEAD_BEEF; lsu_wstrb = 4'hF; lsu_awvalid = 1;
        lsu_araddr = 32'h8000_0004; lsu_arsize = 3'd2; lsu_arvalid = 1;
        ifu_araddr = 32'h8000_0000; ifu_arvalid = 1;
        wait_drain();

        ld_q.push_back(32'h8000_0005); ld_q.push_back(32'h8000_0001);
        ld_q.push_back(32'h8000_0005); ld_q.push_back(32'h8000_0001);
        push(1, 32'h0055_6677, 1'b0, -1); push(1, 32'h0011_2233, 1'b0, -1);
        push(1, 32'h0055_6677, 1'b0, -1); push(1, 32'h0011_2233, 1'b0, -1);
        push(0, 32'h5566_7788, 1'b0, -1); push(1, 32'h0055_6677, 1'b0, -1);
        lsu_araddr = 32'h8000_0001; lsu_arsize = 3'd0; lsu_arvalid = 1;
        ifu_araddr = 32'h8000_0000; ifu_arvalid = 1;
        wait_drain();
        check("starve_cnt_cleared", 64'(dut.starve_cnt), 64'd0);

        begin
            int k = 0;
            lsu_araddr = 32'h8000_0004; lsu_arsize = 3'd2; lsu_arvalid = 1;
            while (!io_master_rready && k < 20) begin @(negedge clk); k++; end
            check("rd_d_reached", 64'(io_master_rready), 64'd1);
            #1 rst = 1;
            #1;
            check("rst_mid_valids", 64'({io_master_arvalid, io_master_rready}), 64'd0);
            check("rst_mid_pulses", 64'({lsu_rvalid_o, ifu_rvalid_o, err_o}), 64'd0);
            lsu_arvalid = 0;
            @(negedge clk); @(negedge clk);
            rst = 0;
            @(negedge clk);
        end
        load(32'h8000_0000, 3'd2, 32'h5566_7788, 1'b0, 3);
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ysyx_axi_req_sched.md
Name: ysyx_axi_req_sched

Overview:
Sequences single-beat AXI4 master transactions and shares one master port between the IFU fetch path and the LSU load/store paths. Each transaction is issued from registered state, and every VALID is held until the slave accepts it. Read data is steered to the winner from the correct 32-bit lane, and a one-cycle completion pulse is returned. The block sits between the core fetch/memory stages and the io_master AXI4 port.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, requester data width
STARVE_MAX, 4, consecutive LSU grants tolerated while the IFU is pending before the IFU is forced to win (1..15)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
ifu_arvalid  in  1  fetch request; held until ifu_rvalid_o
ifu_araddr  in  ADDR_W  fetch address
ifu_rdata_o  out  DATA_W  fetch data, valid with ifu_rvalid_o
ifu_rvalid_o  out  1  one-cycle fetch completion pulse
lsu_arvalid  in  1  load request; held until lsu_rvalid_o
lsu_araddr  in  ADDR_W  load address
lsu_arsize  in  3  AXI size for the load
lsu_rdata_o  out  DATA_W  load data, right-justified
lsu_rvalid_o  out  1  one-cycle load completion pulse
lsu_awvalid  in  1  store request; held until lsu_wready_o
lsu_awaddr  in  ADDR_W  store address
lsu_wdata  in  DATA_W  store data, right-justified
lsu_wstrb  in  4  byte enables, right-justified
lsu_wready_o  out  1  one-cycle store completion pulse
err_o  out  1  one-cycle pulse when the completing RRESP/BRESP is non-zero
io_master_ar{valid,addr,size,id,len,burst}  out  1/ADDR_W/3/4/8/2  AR channel
io_master_arready  in  1
io_master_r{valid,data,resp,last,id}  in  1/64/2/1/4  R channel
io_master_rready  out  1
io_master_aw{valid,addr,size,id,len,burst}  out  1/ADDR_W/3/4/8/2  AW channel
io_master_awready  in  1
io_master_w{valid,data,strb,last}  out  1/64/8/1  W channel
io_master_wready  in  1
io_master_b{valid,resp,id}  in  1/2/4  B channel
io_master_bready  out  1

Behaviour:
- Reset (asynchronous, immediate): state=IDLE; starve counter=0; all io_master_*valid, rready, bready, *_o pulses and err_o = 0. Data outputs = 0.
- Constant fields: arlen=awlen=0, arburst=awburst=2'b01, arid=awid=0, wlast=1 whenever wvalid=1.
- FSM states: IDLE, RD_A, RD_D, WR_AW, WR_B.
- IDLE arbitration, evaluated every cycle:
  - If starve count = STARVE_MAX and ifu_arvalid: grant IFU.
  - Otherwise priority is store > load > fetch.
  - Grant latches owner, address and size/strobe into registers.
  - A read grant goes to RD_A; a store grant goes to WR_AW.
- Starve counter: increments when an LSU grant occurs while ifu_arvalid=1; clears on an IFU grant; saturates at STARVE_MAX.
- RD_A: arvalid=1, driven from the latched registers (first assertion is one cycle after the grant). The arvalid&arready handshake moves to RD_D.
- RD_D: rready=1. On rvalid:
  - Lane select: latched addr[2]=1 takes rdata[63:32], otherwise rdata[31:0].
  - The selected lane is shifted right by 8*addr[1:0].
  - The result is registered into the owner's rdata_o.
  - The owner's rvalid_o pulses the next cycle; err_o pulses with it if rresp≠0.
  - Return to IDLE; a new arbitration can occur in the same cycle the pulse is visible.
- WR_AW: awvalid and wvalid are asserted together.
  - wdata = {w,w}, where w = lsu_wdata << 8*addr[1:0].
  - wstrb = (lsu_wstrb << addr[1:0]) placed in the upper nibble if addr[2]=1, else the lower nibble.
  - Each channel drops its VALID independently after its own handshake (aw_done/w_done flags).
  - Either order, or both in the same cycle, is legal.
  - When both are done, go to WR_B.
- WR_B: bready=1. On bvalid, lsu_wready_o pulses the next cycle (err_o if bresp≠0), then IDLE.
- Size encoding: awsize is derived from the strobe popcount (1→0, 2→1, 4→2); any other strobe value → 2.
- Minimum latency with a zero-wait slave:
  - Read: grant → rvalid_o is 4 cycles (grant, AR, R, pulse).
  - Write: grant → wready_o is 4 cycles.
- Requester withdraws mid-transaction: the bus transaction still completes and the pulse is still issued; the requester ignores it.
- Only one outstanding transaction at any time; unexpected rvalid/bvalid outside RD_D/WR_B is ignored, since rready/bready are 0.

Test Plan:
- Simultaneous ifu_arvalid, lsu_arvalid and lsu_awvalid in one cycle → order store, load, fetch, with exactly one *_o pulse each, in that order.
- Load addr 0x80000006, rdata=0x11223344_55667788 → lsu_rdata_o=0x00001122; arsize equals lsu_arsize.
- Store addr 0x80000005, wdata=0xAB, wstrb=0x1 → wstrb=8'h20, wdata=0x0000AB00_0000AB00; awready arrives 3 cycles after wready → one lsu_wready_o pulse only after bvalid.
- IFU pending while the LSU issues back-to-back loads (STARVE_MAX=4) → IFU granted after the 4th LSU grant; counter returns to 0.
- arready held low for 5 cycles → arvalid and araddr remain stable throughout; rresp=2'b10 → err_o and lsu_rvalid_o pulse in the same cycle.
- rst asserted during RD_D → arvalid/rready/pulses drop within the same cycle; after release, state is IDLE and the next request completes normally.
